// File: rtl/band_mix_sequencer.sv
// Weighted recombination of per-band samples for both stereo channels using one
// shared multiply-accumulate, sequenced left bands then right bands each frame.
module band_mix_sequencer #(
  parameter int NUM_BANDS = 7,
  parameter int SAMPLE_W  = 18,
  parameter int WEIGHT_W  = 5,
  parameter int SHIFT     = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          ready,
  input  logic [NUM_BANDS*SAMPLE_W-1:0] l_bands,
  input  logic [NUM_BANDS*SAMPLE_W-1:0] r_bands,
  input  logic [NUM_BANDS*WEIGHT_W-1:0] weights,
  output logic [SAMPLE_W-1:0]           l_audio_out,
  output logic [SAMPLE_W-1:0]           r_audio_out,
  output logic                          done,
  output logic                          busy,
  output logic                          overrun
);

  localparam int ACC_W  = SAMPLE_W + WEIGHT_W + 4;
  localparam int PROD_W = SAMPLE_W + WEIGHT_W + 1;
  localparam int SLOT_W = $clog2(2 * NUM_BANDS);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;

  state_t                        state, state_next;
  logic [NUM_BANDS*SAMPLE_W-1:0] l_lat, r_lat;
  logic [NUM_BANDS*WEIGHT_W-1:0] w_lat;
  logic [SLOT_W-1:0]             slot;
  logic signed [ACC_W-1:0]       acc, l_hold, acc_sum;
  logic signed [SAMPLE_W-1:0]    cur_sample;
  logic [WEIGHT_W-1:0]           cur_weight;
  logic signed [PROD_W-1:0]      product;
  logic                          last_left, last_right;

  assign last_left  = (slot == SLOT_W'(NUM_BANDS - 1));
  assign last_right = (slot == SLOT_W'(2 * NUM_BANDS - 1));

  // Slot-indexed operand mux: slots below NUM_BANDS read left, the rest read right.
  always_comb begin
    cur_sample = '0;
    cur_weight = '0;
    for (int unsigned i = 0; i < NUM_BANDS; i++) begin
      if (slot == SLOT_W'(i)) begin
        cur_sample = l_lat[i*SAMPLE_W +: SAMPLE_W];
        cur_weight = w_lat[i*WEIGHT_W +: WEIGHT_W];
      end
      if (slot == SLOT_W'(i + NUM_BANDS)) begin
        cur_sample = r_lat[i*SAMPLE_W +: SAMPLE_W];
        cur_weight = w_lat[i*WEIGHT_W +: WEIGHT_W];
      end
    end
    product = PROD_W'(cur_sample) * PROD_W'($signed({1'b0, cur_weight}));
    acc_sum = acc + {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
  end

  function automatic logic [SAMPLE_W-1:0] shift_sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> SHIFT;
    if (s > SAT_MAX)      shift_sat = SAT_MAX[SAMPLE_W-1:0];
    else if (s < SAT_MIN) shift_sat = SAT_MIN[SAMPLE_W-1:0];
    else                  shift_sat = s[SAMPLE_W-1:0];
  endfunction

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ready) state_next = MAC;
      MAC:     if (last_right) state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      l_lat       <= '0;
      r_lat       <= '0;
      w_lat       <= '0;
      slot        <= '0;
      acc         <= '0;
      l_hold      <= '0;
      l_audio_out <= '0;
      r_audio_out <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ready && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (ready) begin
            l_lat <= l_bands;
            r_lat <= r_bands;
            w_lat <= weights;
            acc   <= '0;
            slot  <= '0;
            busy  <= 1'b1;
          end
        end
        MAC: begin
          slot <= slot + 1'b1;
          // Left total parks in l_hold so the accumulator restarts for the right channel.
          if (last_left) begin
            l_hold <= acc_sum;
            acc    <= '0;
          end else begin
            acc <= acc_sum;
          end
        end
        WRITE: begin
          l_audio_out <= shift_sat(l_hold);
          r_audio_out <= shift_sat(acc);
          done        <= 1'b1;
          busy        <= 1'b0;
          slot        <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_band_mix_sequencer.sv
// Directed bench for band_mix_sequencer: latency, mixing, shift/saturation, overrun, reset.
module tb_band_mix_sequencer;
  localparam int NB = 7;
  localparam int SW = 18;
  localparam int WW = 5;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              ready = 1'b0;
  logic [NB*SW-1:0]  l_bands = '0;
  logic [NB*SW-1:0]  r_bands = '0;
  logic [NB*WW-1:0]  weights = '0;
  logic [SW-1:0]     l_audio_out, r_audio_out;
  logic              done, busy, overrun;

  int tests = 0;
  int fails = 0;

  band_mix_sequencer #(.NUM_BANDS(NB), .SAMPLE_W(SW), .WEIGHT_W(WW), .SHIFT(4)) dut (
    .clock(clock), .reset(reset), .ready(ready),
    .l_bands(l_bands), .r_bands(r_bands), .weights(weights),
    .l_audio_out(l_audio_out), .r_audio_out(r_audio_out),
    .done(done), .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  // All tasks begin and end at a negedge; inputs set there are sampled at the next posedge.
  task automatic pulse_ready;
    ready = 1'b1;
    @(negedge clock);
    ready = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      cycles++;
      if (done) break;
    end
    if (!done) cycles = -1;
  endtask

  task automatic set_inputs(input int l[NB], input int r[NB], input int w[NB]);
    for (int i = 0; i < NB; i++) begin
      l_bands[i*SW +: SW] = SW'(l[i]);
      r_bands[i*SW +: SW] = SW'(r[i]);
      weights[i*WW +: WW] = WW'(w[i]);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    tests++;
    if ({l_audio_out, r_audio_out, done, busy, overrun} !== '0) begin
      fails++;
      $display("FAIL reset_state: got l=%0d r=%0d done=%b busy=%b ovr=%b, expected all 0",
               $signed(l_audio_out), $signed(r_audio_out), done, busy, overrun);
    end
  endtask

  task automatic test_unity;
    int l[NB] = '{1000, 0, 0, 0, 0, 0, 0};
    int r[NB] = '{0, 0, 0, -500, 0, 0, 0};
    int w[NB] = '{16, 16, 16, 16, 16, 16, 16};
    int bad = 0;
    set_inputs(l, r, w);
    pulse_ready();
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL unity_edge0: got busy=%b done=%b, expected busy=1 done=0", busy, done);
    end
    for (int e = 1; e <= 15; e++) begin
      @(negedge clock);
      if (busy !== (e <= 14) || done !== (e == 15)) begin
        bad++;
        $display("FAIL unity_timing edge %0d: got busy=%b done=%b, expected busy=%b done=%b",
                 e, busy, done, e <= 14, e == 15);
      end
    end
    tests++;
    if (bad != 0) fails++;
    tests++;
    if ($signed(l_audio_out) !== 1000 || $signed(r_audio_out) !== -500) begin
      fails++;
      $display("FAIL unity_value: got l=%0d r=%0d, expected l=1000 r=-500",
               $signed(l_audio_out), $signed(r_audio_out));
    end
    @(negedge clock);
    tests++;
    if (done !== 1'b0 || $signed(l_audio_out) !== 1000) begin
      fails++;
      $display("FAIL unity_hold: got done=%b l=%0d, expected done=0 l=1000",
               done, $signed(l_audio_out));
    end
  endtask

  task automatic test_mix;
    int l[NB] = '{100, 200, 300, 400, 500, 600, 700};
    int r[NB] = '{-10, -20, -30, -40, -50, -60, -70};
    int w[NB] = '{0, 1, 2, 3, 4, 5, 6};
    int cyc;
    set_inputs(l, r, w);
    pulse_ready();
    wait_done(cyc);
    tests++;
    // left sum 11200 >>> 4 = 700; right sum -1120 >>> 4 = -70
    if (cyc !== 15 || $signed(l_audio_out) !== 700 || $signed(r_audio_out) !== -70) begin
      fails++;
      $display("FAIL mix_weights: got cycles=%0d l=%0d r=%0d, expected cycles=15 l=700 r=-70",
               cyc, $signed(l_audio_out), $signed(r_audio_out));
    end
  endtask

  task automatic test_saturation;
    int lp[NB] = '{131071, 131071, 131071, 131071, 131071, 131071, 131071};
    int ln[NB] = '{-131072, -131072, -131072, -131072, -131072, -131072, -131072};
    int w[NB]  = '{31, 31, 31, 31, 31, 31, 31};
    int cyc;
    set_inputs(lp, lp, w);
    pulse_ready();
    wait_done(cyc);
    tests++;
    if (cyc !== 15 || $signed(l_audio_out) !== 131071 || $signed(r_audio_out) !== 131071) begin
      fails++;
      $display("FAIL sat_pos: got cycles=%0d l=%0d r=%0d, expected 15 131071 131071",
               cyc, $signed(l_audio_out), $signed(r_audio_out));
    end
    set_inputs(ln, ln, w);
    pulse_ready();
    wait_done(cyc);
    tests++;
    if (cyc !== 15 || $signed(l_audio_out) !== -131072 || $signed(r_audio_out) !== -131072) begin
      fails++;
      $display("FAIL sat_neg: got cycles=%0d l=%0d r=%0d, expected 15 -131072 -131072",
               cyc, $signed(l_audio_out), $signed(r_audio_out));
    end
  endtask

  task automatic test_floor;
    int lm[NB] = '{-1, 0, 0, 0, 0, 0, 0};
    int lp[NB] = '{15, 0, 0, 0, 0, 0, 0};
    int lz[NB] = '{1000, 0, 0, 0, 0, 0, 0};
    int z[NB]  = '{0, 0, 0, 0, 0, 0, 0};
    int w1[NB] = '{1, 0, 0, 0, 0, 0, 0};
    int w0[NB] = '{0, 16, 16, 16, 16, 16, 16};
    int cyc;
    set_inputs(lm, z, w1);
    pulse_ready();
    wait_done(cyc);
    tests++;
    if ($signed(l_audio_out) !== -1 || $signed(r_audio_out) !== 0) begin
      fails++;
      $display("FAIL floor_neg: got l=%0d r=%0d, expected l=-1 r=0",
               $signed(l_audio_out), $signed(r_audio_out));
    end
    set_inputs(lp, z, w1);
    pulse_ready();
    wait_done(cyc);
    tests++;
    if ($signed(l_audio_out) !== 0) begin
      fails++;
      $display("FAIL floor_pos: got l=%0d, expected 0", $signed(l_audio_out));
    end
    set_inputs(lz, lz, w0);
    pulse_ready();
    wait_done(cyc);
    tests++;
    if ($signed(l_audio_out) !== 0 || $signed(r_audio_out) !== 0) begin
      fails++;
      $display("FAIL weight_zero: got l=%0d r=%0d, expected 0 0",
               $signed(l_audio_out), $signed(r_audio_out));
    end
  endtask

  task automatic test_overrun;
    int l[NB]  = '{100, 0, 0, 0, 0, 0, 0};
    int l2[NB] = '{7777, 0, 0, 0, 0, 0, 0};
    int r[NB]  = '{0, 200, 0, 0, 0, 0, 0};
    int w[NB]  = '{16, 16, 16, 16, 16, 16, 16};
    int bad = 0;
    int cyc;
    do_reset();
    set_inputs(l, r, w);
    pulse_ready();
    for (int e = 1; e <= 15; e++) begin
      if (e == 5) begin
        ready = 1'b1;
        set_inputs(l2, r, w);
      end
      @(negedge clock);
      ready = 1'b0;
      if (overrun !== (e >= 5) || done !== (e == 15)) begin
        bad++;
        $display("FAIL overrun_timing edge %0d: got ovr=%b done=%b, expected ovr=%b done=%b",
                 e, overrun, done, e >= 5, e == 15);
      end
    end
    tests++;
    if (bad != 0) fails++;
    tests++;
    if ($signed(l_audio_out) !== 100 || $signed(r_audio_out) !== 200) begin
      fails++;
      $display("FAIL overrun_frame0: got l=%0d r=%0d, expected l=100 r=200",
               $signed(l_audio_out), $signed(r_audio_out));
    end
    pulse_ready();
    wait_done(cyc);
    tests++;
    if (cyc !== 15 || $signed(l_audio_out) !== 7777 || overrun !== 1'b1) begin
      fails++;
      $display("FAIL back_to_back: got cycles=%0d l=%0d ovr=%b, expected 15 7777 1",
               cyc, $signed(l_audio_out), overrun);
    end
  endtask

  task automatic test_isolation;
    int l[NB]  = '{1000, 0, 0, 0, 0, 0, 0};
    int l2[NB] = '{5000, 5000, 5000, 5000, 5000, 5000, 5000};
    int z[NB]  = '{0, 0, 0, 0, 0, 0, 0};
    int w[NB]  = '{16, 16, 16, 16, 16, 16, 16};
    int w2[NB] = '{1, 1, 1, 1, 1, 1, 1};
    int cyc;
    set_inputs(l, z, w);
    pulse_ready();
    repeat (2) @(negedge clock);
    set_inputs(l2, l2, w2);
    wait_done(cyc);
    tests++;
    if (cyc !== 13 || $signed(l_audio_out) !== 1000 || $signed(r_audio_out) !== 0) begin
      fails++;
      $display("FAIL isolation: got cycles=%0d l=%0d r=%0d, expected 13 1000 0",
               cyc, $signed(l_audio_out), $signed(r_audio_out));
    end
  endtask

  task automatic test_reset_mid;
    int l[NB] = '{3000, 0, 0, 0, 0, 0, 0};
    int r[NB] = '{0, 0, 0, 0, 0, 0, -2000};
    int w[NB] = '{16, 16, 16, 16, 16, 16, 16};
    int bad = 0;
    int cyc;
    set_inputs(l, r, w);
    pulse_ready();
    repeat (6) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    tests++;
    if ({l_audio_out, r_audio_out, done, busy, overrun} !== '0) begin
      fails++;
      $display("FAIL reset_mid_state: got l=%0d r=%0d done=%b busy=%b ovr=%b, expected all 0",
               $signed(l_audio_out), $signed(r_audio_out), done, busy, overrun);
    end
    for (int e = 8; e <= 9; e++) begin
      @(negedge clock);
      if (done !== 1'b0) bad++;
    end
    for (int n = 0; n < 20 && !done; n++) @(negedge clock);
    tests++;
    if (bad != 0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_no_done: got done pulses=%0d, expected 0", bad + done);
    end
    pulse_ready();
    wait_done(cyc);
    tests++;
    if (cyc !== 15 || $signed(l_audio_out) !== 3000 || $signed(r_audio_out) !== -2000) begin
      fails++;
      $display("FAIL reset_mid_restart: got cycles=%0d l=%0d r=%0d, expected 15 3000 -2000",
               cyc, $signed(l_audio_out), $signed(r_audio_out));
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_unity();
    test_mix();
    test_saturation();
    test_floor();
    test_overrun();
    test_isolation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
